// File: rtl/regfile_rmw_pkg.sv
// Shared types for the read-modify-write register file: operation encoding
// and its width.
package regfile_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

endpackage

// File: rtl/regfile_rmw_read_port.sv
// One tristate read port: range-checks the address, selects a register from
// the flattened storage image and drives the bus only while oe is high.
module regfile_read_port #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  input  logic                   oe,
  input  logic [ADDR_W-1:0]      raddr,
  inout  wire  [WIDTH-1:0]       rdata
);

  logic             in_range;
  logic [WIDTH-1:0] rd_val;

  assign in_range = {1'b0, raddr} < (ADDR_W + 1)'(DEPTH);

  // Holes in a non-power-of-two address map read back as zero.
  always_comb begin
    rd_val = '0;
    if (in_range) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr == ADDR_W'(i)) begin
          rd_val = mem_flat[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign rdata = oe ? rd_val : {WIDTH{1'bz}};

endmodule

// File: rtl/regfile_rmw.sv
// Parametrised register file with two tristate read ports and a single
// write port that can load, increment, decrement or clear a register in place.
module regfile_rmw
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              oe_a,
  input  logic [ADDR_W-1:0] raddr_a,
  inout  wire  [WIDTH-1:0]  rdata_a,
  input  logic              oe_b,
  input  logic [ADDR_W-1:0] raddr_b,
  inout  wire  [WIDTH-1:0]  rdata_b,
  output logic [WIDTH-1:0]  tap0,
  output logic [WIDTH-1:0]  tap1,
  output logic              zero,
  output logic              carry
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  op_t              op_e;
  logic             waddr_ok;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  logic             result_carry;

  logic [DEPTH*WIDTH-1:0] mem_flat;

  assign op_e     = op_t'(op);
  assign waddr_ok = {1'b0, waddr} < (ADDR_W + 1)'(DEPTH);

  always_comb begin
    opnd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == ADDR_W'(i)) begin
        opnd = mem_q[i];
      end
    end
  end

  // Shared adder: decrement adds all-ones, so its carry-out is low only
  // when the operand was zero, i.e. exactly when the decrement wraps.
  assign addend = (op_e == OP_DEC) ? {WIDTH{1'b1}} : WIDTH'(1);
  assign sum    = {1'b0, opnd} + {1'b0, addend};

  always_comb begin
    result       = '0;
    result_carry = 1'b0;
    case (op_e)
      OP_LOAD: result = wdata;
      OP_INC: begin
        result       = sum[WIDTH-1:0];
        result_carry = sum[WIDTH];
      end
      OP_DEC: begin
        result       = sum[WIDTH-1:0];
        result_carry = ~sum[WIDTH];
      end
      OP_CLR: result = '0;
      default: result = '0;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      zero_d  = 1'b0;
      carry_d = 1'b0;
    end else if (we && waddr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) begin
          mem_d[i] = result;
        end
      end
      zero_d  = (result == '0);
      carry_d = result_carry;
    end
  end

  always_ff @(posedge clk) begin
    mem_q   <= mem_d;
    zero_q  <= zero_d;
    carry_q <= carry_d;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*WIDTH +: WIDTH] = mem_q[g];
  end

  regfile_read_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .mem_flat (mem_flat),
    .oe       (oe_a),
    .raddr    (raddr_a),
    .rdata    (rdata_a)
  );

  regfile_read_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .mem_flat (mem_flat),
    .oe       (oe_b),
    .raddr    (raddr_b),
    .rdata    (rdata_b)
  );

  assign tap0  = mem_q[0];
  assign tap1  = mem_q[1];
  assign zero  = zero_q;
  assign carry = carry_q;

endmodule
